// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: bundle of the control-sequencer handshake and datapath
// enable signals. The master modport is the side that supplies the machine
// word and ALU flags; the slave modport is the sequencer itself.
interface ctrl_seq_if #(
  parameter int IW = 9
);
  logic          Start;
  logic [IW-1:0] Instruction;
  logic          AluOvf;
  logic          Zero;
  logic          RegWrEn;
  logic          MemWrite;
  logic          MemRead;
  logic          AccWrEn;
  logic          LookUp;
  logic          BranchEn;
  logic          IsOverflow;
  logic          Ack;
  logic          Stall;
  logic          Err;

  modport master (
    output Start, Instruction, AluOvf, Zero,
    input  RegWrEn, MemWrite, MemRead, AccWrEn, LookUp, BranchEn,
    input  IsOverflow, Ack, Stall, Err
  );

  modport slave (
    input  Start, Instruction, AluOvf, Zero,
    output RegWrEn, MemWrite, MemRead, AccWrEn, LookUp, BranchEn,
    output IsOverflow, Ack, Stall, Err
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: four-state instruction sequencer (IDLE/RUN/MEMWAIT/HALTED).
// Decodes the current machine word into datapath enables, stretches loads
// over MEM_LAT cycles, keeps a sticky ALU overflow flag and halts on 'halt'.
// Enables are combinational from state and Instruction; state, load
// counter, sticky flag and Err are registered.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make opcode 1111 trap
// (set Err, halt, ignore Start until Reset). Without it 1111 is a nop and
// Err is tied low. IW must be at least 6, MEM_LAT at least 1.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int MEM_LAT = 2
) (
  input logic       Clk,
  input logic       Reset,
  ctrl_seq_if.slave bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LOAD = 4'd2;
  localparam logic [3:0] OP_STR  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_CPY  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLR  = 4'd9;
  localparam logic [3:0] OP_RST  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_LT   = 4'd13;
  localparam logic [3:0] OP_EQL  = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ovf_set_s, ovf_clr_s;
  logic          err_set_s;
  logic          trapped_s;
  logic          type_s;
  logic [3:0]    op_s;
  logic          regwr_s, memwr_s, memrd_s, accwr_s, lookup_s, branch_s;
  logic          ack_s, stall_s;

  assign type_s = bus.Instruction[IW-1];
  assign op_s   = bus.Instruction[IW-2:IW-5];

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q;

  // Trap flag: set by an illegal opcode, held until Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (err_set_s) begin
      err_q <= 1'b1;
    end
  end

  assign trapped_s = err_q;
  assign bus.Err   = err_q;
`else
  assign trapped_s = 1'b0;
  assign bus.Err   = 1'b0;
`endif

  // Next-state, load counter, sticky-flag controls and datapath enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_set_s = 1'b0;
    ovf_clr_s = 1'b0;
    err_set_s = 1'b0;
    regwr_s   = 1'b0;
    memwr_s   = 1'b0;
    memrd_s   = 1'b0;
    accwr_s   = 1'b0;
    lookup_s  = 1'b0;
    branch_s  = 1'b0;
    ack_s     = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_s = 1'b1;
        if (bus.Start) state_d = S_RUN;
        else           state_d = S_IDLE;
      end
      S_RUN: begin
        if (type_s) begin
          accwr_s = 1'b1;
        end else begin
          case (op_s)
            OP_ADD, OP_SUB: begin
              accwr_s   = 1'b1;
              ovf_set_s = bus.AluOvf;
            end
            OP_LOAD: begin
              memrd_s = 1'b1;
              // A single-cycle memory finishes the load right here.
              if (MEM_LAT > 1) begin
                stall_s = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = S_MEMWAIT;
              end else begin
                accwr_s = 1'b1;
              end
            end
            OP_STR: memwr_s = 1'b1;
            OP_MOV, OP_NAND, OP_OR, OP_SLL, OP_SLR, OP_LT, OP_EQL: accwr_s = 1'b1;
            OP_CPY: regwr_s = 1'b1;
            OP_RST: ovf_clr_s = 1'b1;
            OP_HALT: state_d = S_HALTED;
            OP_BNE: begin
              lookup_s = 1'b1;
              branch_s = ~bus.Zero;
            end
            OP_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              err_set_s = 1'b1;
              state_d   = S_HALTED;
`else
              err_set_s = 1'b0;
`endif
            end
            default: state_d = S_RUN;
          endcase
        end
      end
      S_MEMWAIT: begin
        memrd_s = 1'b1;
        // Counter holds the cycles still to go; the last one writes the acc.
        if (cnt_q > CNT_ONE) begin
          stall_s = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          accwr_s = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = S_RUN;
        end
      end
      S_HALTED: begin
        ack_s   = 1'b1;
        stall_s = 1'b1;
        if (bus.Start && !trapped_s) state_d = S_RUN;
        else                         state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky overflow: a set in the same cycle as a clear takes priority.
  always_comb begin
    if (ovf_set_s)      ovf_d = 1'b1;
    else if (ovf_clr_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // State, load counter and sticky flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.RegWrEn    = regwr_s;
  assign bus.MemWrite   = memwr_s;
  assign bus.MemRead    = memrd_s;
  assign bus.AccWrEn    = accwr_s;
  assign bus.LookUp     = lookup_s;
  assign bus.BranchEn   = branch_s;
  assign bus.IsOverflow = ovf_q;
  assign bus.Ack        = ack_s;
  assign bus.Stall      = stall_s;

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter IW, default 9: instruction width; bit IW-1 is the type bit, bits IW-2:IW-5 are the opcode; IW SHALL be at least 6.
REQ-002 Parameter MEM_LAT, default 2: load latency in cycles; MEM_LAT SHALL be at least 1.
REQ-003 Port Clk  in  1: the single clock.
REQ-004 Port Reset  in  1: asynchronous, active-high reset.
REQ-005 Port Start  in  1: one-cycle pulse that begins or resumes execution.
REQ-006 Port Instruction  in  IW: current machine word.
REQ-007 Port AluOvf  in  1: ALU overflow for the current add/sub.
REQ-008 Port Zero  in  1: ALU zero flag.
REQ-009 Ports RegWrEn, MemWrite, MemRead, AccWrEn, LookUp, BranchEn  out  1 each: datapath enables.
REQ-010 Port IsOverflow  out  1: sticky overflow flag.
REQ-011 Port Ack  out  1: program done.
REQ-012 Port Stall  out  1: PC hold.
REQ-013 Port Err  out  1: illegal-opcode trap flag (see REQ-030).

Function
REQ-014 The block SHALL be a 4-state FSM: IDLE, RUN, MEMWAIT, HALTED.
REQ-015 IDLE SHALL drive all enables 0, Ack 0 and Stall 1; Start SHALL move it to RUN.
REQ-016 In RUN, type bit = 1 SHALL assert AccWrEn only.
REQ-017 In RUN with type bit = 0, the opcode SHALL decode as follows; all enables not listed are 0:
- 0000 add, 0001 sub: AccWrEn.
- 0010 load: MemRead; go to MEMWAIT.
- 0011 store: MemWrite.
- 0100 mov, 0110 nand, 0111 or, 1000 sll, 1001 slr, 1101 lt, 1110 eql: AccWrEn.
- 0101 cpy: RegWrEn.
- 1010 rst: clear the sticky overflow flag.
- 1011 halt: go to HALTED.
- 1100 bne: LookUp = 1, BranchEn = !Zero.
- 1111: illegal.
REQ-018 Load timing:
- MemRead SHALL stay high in RUN for the load cycle and in every MEMWAIT cycle.
- Stall SHALL be 1 for MEM_LAT-1 cycles.
- AccWrEn SHALL assert only in the final load cycle, after which the FSM returns to RUN.
- With MEM_LAT = 1, a load SHALL complete in one cycle with no MEMWAIT and no stall.
REQ-019 The MEMWAIT counter SHALL be ceil(log2(MEM_LAT+1)) bits wide and SHALL load MEM_LAT-1 on entry.
REQ-020 The sticky overflow flag SHALL set on the clock edge of an add or sub with AluOvf = 1.
REQ-021 The sticky overflow flag SHALL clear on rst; when both occur in one cycle, the set SHALL win.
REQ-022 IsOverflow SHALL equal the sticky overflow flag.
REQ-023 HALTED SHALL drive Ack 1, Stall 1 and all enables 0; Start SHALL return it to RUN with Ack 0 on the next cycle.
REQ-024 Start SHALL be ignored in RUN and MEMWAIT.
REQ-025 Stall SHALL be 0 in RUN except on a load with MEM_LAT > 1.
REQ-026 Outputs SHALL be combinational from state and Instruction; the state, counter, sticky flag and Err SHALL be registered.

Reset
REQ-027 Reset SHALL asynchronously force state IDLE, counter 0, sticky overflow 0 and Err 0.
REQ-028 Reset asserted mid-MEMWAIT or in HALTED SHALL abort immediately; outputs SHALL be IDLE values in the same cycle.
REQ-029 Start SHALL be ignored while Reset is high.

Configuration
REQ-030 With macro CTRL_ILLEGAL_TRAP_EN defined, opcode 1111 SHALL set Err, move to HALTED and assert Ack; Err SHALL stay set until Reset, and Start from a trapped halt SHALL be ignored.
REQ-031 With CTRL_ILLEGAL_TRAP_EN undefined, opcode 1111 SHALL be a nop with all enables 0, and Err SHALL be tied to 0.

Verification
REQ-032 Reset, then Start, then Instruction 9'b000000000 -> AccWrEn = 1, Stall = 0, all other enables 0.
REQ-033 MEM_LAT = 3, load 9'b000100000 -> MemRead high for 3 cycles, Stall high for the first 2, AccWrEn only on the 3rd; MEM_LAT = 1 -> single cycle, Stall = 0.
REQ-034 bne with Zero = 0 -> BranchEn = 1, LookUp = 1; bne with Zero = 1 -> BranchEn = 0, LookUp = 1.
REQ-035 add with AluOvf = 1 -> IsOverflow = 1 persists across 5 movs; rst -> IsOverflow = 0 next cycle; sub with AluOvf = 1 -> IsOverflow = 1.
REQ-036 halt -> Ack = 1, Stall = 1 held 10 cycles; Start -> Ack = 0, RUN; Reset pulsed during MEMWAIT -> IDLE, MemRead = 0 immediately.
REQ-037 Opcode 1111: with CTRL_ILLEGAL_TRAP_EN -> Err = 1, Ack = 1, Start ignored; without -> all outputs 0, execution continues.
